// File: rtl/loader_pkg.sv
// Shared definitions for the boot-stream instruction memory loader.
// Holds the FSM state encoding and the default frame start marker.
package loader_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN0  = 3'd1,
    ST_LEN1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_CSUM  = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
  } loader_state_e;

endpackage

// File: rtl/imem_loader.sv
// Boot loader: parses a SYNC / length / data / checksum byte stream and
// writes little-endian 32-bit words into instruction memory while holding the core.
module imem_loader
  import loader_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  Byte_Data,
  input  logic        Byte_Valid,
  output logic        Byte_Ready,
  input  logic        Restart,
  output logic        Imem_WrEn,
  output logic [31:0] Imem_WrAddr,
  output logic [31:0] Imem_WrData,
  output logic        Cpu_Hold,
  output logic        Done,
  output logic        Error
);

  loader_state_e state_q, state_d;
  logic [15:0]   len_q, len_d;
  logic [15:0]   word_idx_q, word_idx_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [7:0]    sum_q, sum_d;
  logic [23:0]   word_q, word_d;
  logic          wr_en_q, wr_en_d;
  logic [31:0]   wr_addr_q, wr_addr_d;
  logic [31:0]   wr_data_q, wr_data_d;

  logic          accept;
  logic [15:0]   len_full;
  logic          last_word;

  assign accept    = Byte_Valid & Byte_Ready;
  assign len_full  = {Byte_Data, len_q[7:0]};
  assign last_word = (word_idx_q == (len_q - 16'd1));

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      sum_q      <= '0;
      word_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      byte_cnt_q <= byte_cnt_d;
      sum_q      <= sum_d;
      word_q     <= word_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && Byte_Data == SYNC_BYTE) state_d = ST_LEN0;
      ST_LEN0: if (accept) state_d = ST_LEN1;
      ST_LEN1: begin
        if (accept) begin
          if ({16'd0, len_full} > DEPTH) state_d = ST_ERROR;
          else if (len_full == 16'd0)    state_d = ST_CSUM;
          else                           state_d = ST_DATA;
        end
      end
      ST_DATA: if (accept && byte_cnt_q == 2'd3 && last_word) state_d = ST_CSUM;
      ST_CSUM: if (accept) state_d = (Byte_Data == sum_q) ? ST_DONE : ST_ERROR;
      ST_DONE, ST_ERROR: if (Restart) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Counters, checksum and word assembly; write address/data hold between strobes
  always_comb begin
    len_d      = len_q;
    word_idx_d = word_idx_q;
    byte_cnt_d = byte_cnt_q;
    sum_d      = sum_q;
    word_d     = word_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && Byte_Data == SYNC_BYTE) begin
          len_d      = '0;
          word_idx_d = '0;
          byte_cnt_d = '0;
          sum_d      = '0;
        end
      end
      ST_LEN0: if (accept) len_d[7:0]  = Byte_Data;
      ST_LEN1: if (accept) len_d[15:8] = Byte_Data;
      ST_DATA: begin
        if (accept) begin
          sum_d      = sum_q + Byte_Data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: word_d[7:0]   = Byte_Data;
            2'd1: word_d[15:8]  = Byte_Data;
            2'd2: word_d[23:16] = Byte_Data;
            default: begin
              wr_en_d    = 1'b1;
              wr_addr_d  = {14'd0, word_idx_q, 2'b00};
              wr_data_d  = {Byte_Data, word_q};
              word_idx_d = word_idx_q + 16'd1;
            end
          endcase
        end
      end
      ST_DONE, ST_ERROR: begin
        if (Restart) begin
          len_d      = '0;
          word_idx_d = '0;
          byte_cnt_d = '0;
          sum_d      = '0;
        end
      end
      default: ;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    Byte_Ready = 1'b0;
    Done       = 1'b0;
    Error      = 1'b0;
    Cpu_Hold   = 1'b1;
    case (state_q)
      ST_IDLE, ST_LEN0, ST_LEN1, ST_DATA, ST_CSUM: Byte_Ready = 1'b1;
      ST_DONE: begin
        Done     = 1'b1;
        Cpu_Hold = 1'b0;
      end
      ST_ERROR: Error = 1'b1;
      default: ;
    endcase
  end

  assign Imem_WrEn   = wr_en_q;
  assign Imem_WrAddr = wr_addr_q;
  assign Imem_WrData = wr_data_q;

endmodule
